// File: rtl/rw_pkg.sv
// Shared definitions for the random-walk BRAM arbiter and its clients.
package rw_pkg;

    localparam int ADDR_WIDTH = 13;
    localparam int DATA_WIDTH = 32;

    // Table base offsets inside the shared BRAM
    localparam int NEI_ADDR_TABLE_OFFSET = 10;
    localparam int NEI_TABLE_OFFSET      = 100;
    localparam int SCORE_TABLE_OFFSET    = 1000;

    // Requester IDs (bit positions in req/gnt vectors)
    localparam int REQ_WALK  = 0;
    localparam int REQ_SCORE = 1;

    // Arbiter ownership state
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_e;

    // Requesters allowed to be granted in a given state
    function automatic logic [1:0] allowed_mask(arb_state_e s);
        case (s)
            ST_LOCK0: allowed_mask = 2'b01;
            ST_LOCK1: allowed_mask = 2'b10;
            default:  allowed_mask = 2'b11;
        endcase
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with its own last-grant pointer.
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,       // already masked by the lock state
    input  logic       i_force,     // override the pointer (forced lock release)
    input  logic       i_force_id,  // value written to the pointer on override
    output logic [1:0] o_gnt
);

    logic last_q, last_d;

    // Grant selection: lone requester wins; on contention the one not granted last wins
    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = last_q ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
        last_d = last_q;
        if (i_force)       last_d = i_force_id;
        else if (o_gnt[1]) last_d = 1'b1;
        else if (o_gnt[0]) last_d = 1'b0;
    end

    // Pointer register; reset value makes requester 0 win the first contention
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) last_q <= 1'b1;
        else          last_q <= last_d;
    end

endmodule

// File: rtl/rw_bram_arbiter.sv
// Shares the single-port random-walk BRAM between the walker and the score
// accumulator: round-robin arbitration plus an RMW lock with forced release.
module rw_bram_arbiter #(
    parameter int ADDR_WIDTH      = rw_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH      = rw_pkg::DATA_WIDTH,
    parameter int MAX_LOCK_CYCLES = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [1:0]            i_req,
    input  logic [1:0]            i_lock,
    input  logic [1:0]            i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr0,
    input  logic [ADDR_WIDTH-1:0] i_addr1,
    input  logic [DATA_WIDTH-1:0] i_wdata0,
    input  logic [DATA_WIDTH-1:0] i_wdata1,
    output logic [1:0]            o_gnt,
    output logic [1:0]            o_rvalid,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic [ADDR_WIDTH-1:0] o_bram_addr,
    output logic                  o_bram_write,
    output logic [DATA_WIDTH-1:0] o_bram_data,
    input  logic [DATA_WIDTH-1:0] i_bram_data,
    output logic                  o_lock_timeout
);

    import rw_pkg::*;

    localparam int CW = (MAX_LOCK_CYCLES > 2) ? $clog2(MAX_LOCK_CYCLES) : 1;
    localparam logic [CW-1:0] LCNT_MAX = CW'(MAX_LOCK_CYCLES - 1);

    arb_state_e    state_q, state_d;
    logic [CW-1:0] lcnt_q, lcnt_d;
    logic [1:0]    rvalid_q, rvalid_d;
    logic [1:0]    req_eff, gnt_arb, gnt;
    logic          timeout, own, sel;

    assign own     = (state_q == ST_LOCK1);
    assign req_eff = i_req & allowed_mask(state_q);
    assign timeout = (state_q != ST_IDLE) && (lcnt_q == LCNT_MAX);

    rr_arb2 u_rr (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_req      (req_eff),
        .i_force    (timeout),
        .i_force_id (own),
        .o_gnt      (gnt_arb)
    );

    // Nothing is issued while reset is held, even if state has not cleared yet
    assign gnt   = gnt_arb & {2{i_rst_n}};
    assign o_gnt = gnt;
    assign sel   = gnt[REQ_SCORE];

    assign o_bram_addr    = sel ? i_addr1  : i_addr0;
    assign o_bram_data    = sel ? i_wdata1 : i_wdata0;
    assign o_bram_write   = (|gnt) & (sel ? i_we[REQ_SCORE] : i_we[REQ_WALK]);
    assign o_rdata        = i_bram_data;
    // A read issued just before reset must not report data during reset
    assign o_rvalid       = rvalid_q & {2{i_rst_n}};
    assign o_lock_timeout = timeout & i_rst_n;
    assign rvalid_d       = gnt & ~i_we;

    // Lock FSM and lock-duration counter: next state
    always_comb begin
        state_d = state_q;
        lcnt_d  = lcnt_q;
        case (state_q)
            ST_IDLE: begin
                lcnt_d = '0;
                if (gnt[REQ_WALK] && i_lock[REQ_WALK])        state_d = ST_LOCK0;
                else if (gnt[REQ_SCORE] && i_lock[REQ_SCORE]) state_d = ST_LOCK1;
            end
            default: begin
                lcnt_d = lcnt_q + CW'(1);
                // leave on forced release, on the final unlocked access,
                // or when the owner has gone quiet and no longer wants the lock
                if (timeout || (gnt[own] && !i_lock[own]) || (!i_req[own] && !i_lock[own]))
                    state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and read-valid pipeline registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            lcnt_q   <= '0;
            rvalid_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            lcnt_q   <= lcnt_d;
            rvalid_q <= rvalid_d;
        end
    end

endmodule

// File: tb/tb_rw_bram_arbiter.sv
// Bench for rw_bram_arbiter: directed scenarios plus random traffic, checked
// against an ownership/memory reference model with a read-data scoreboard.
module tb_rw_bram_arbiter;

    localparam int AW   = 13;
    localparam int DW   = 32;
    localparam int MAXL = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req, lock, we;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [1:0]    gnt, rvalid;
    logic [DW-1:0] rdata, bram_wdata, bram_rdata;
    logic [AW-1:0] bram_addr;
    logic          bram_write, lock_to;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rw_bram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK_CYCLES(MAXL)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_lock(lock), .i_we(we),
        .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_gnt(gnt), .o_rvalid(rvalid), .o_rdata(rdata),
        .o_bram_addr(bram_addr), .o_bram_write(bram_write), .o_bram_data(bram_wdata),
        .i_bram_data(bram_rdata), .o_lock_timeout(lock_to)
    );

    // Single-port BRAM behind the arbiter: write-first not needed, one access per cycle
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bram_write) mem[bram_addr] <= bram_wdata;
        bram_rdata <= mem[bram_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int c; int id; logic [DW-1:0] d; } rd_t;
    rd_t           sbq[$];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            m_own  = -1;   // -1 = nobody holds the lock
    int            m_lcnt = 0;    // cycles spent locked so far
    int            m_last = 1;    // who was granted most recently
    int            m_g;
    logic          m_to;
    logic [1:0]    m_eg;
    logic [AW-1:0] m_a;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_own = -1; m_lcnt = 0; m_last = 1;
            chk("gnt_in_reset", 64'(gnt), 64'd0);
            chk("timeout_in_reset", 64'(lock_to), 64'd0);
        end else begin
            m_g = -1;
            if (m_own < 0) begin
                if (req == 2'b01)      m_g = 0;
                else if (req == 2'b10) m_g = 1;
                else if (req == 2'b11) m_g = 1 - m_last;
            end else if (req[m_own]) begin
                m_g = m_own;
            end
            m_to = (m_own >= 0) && (m_lcnt == MAXL - 1);
            m_eg = (m_g == 0) ? 2'b01 : (m_g == 1) ? 2'b10 : 2'b00;
            chk("gnt", 64'(gnt), 64'(m_eg));
            chk("lock_timeout", 64'(lock_to), 64'(m_to));
            if (m_g >= 0) begin
                m_a = (m_g == 1) ? addr1 : addr0;
                if (we[m_g]) ref_mem[m_a] = (m_g == 1) ? wdata1 : wdata0;
                else         sbq.push_back('{c: cyc, id: m_g, d: ref_mem[m_a]});
                m_last = m_g;
            end
            if (m_own < 0) begin
                if (m_g >= 0 && lock[m_g]) begin m_own = m_g; m_lcnt = 0; end
            end else if (m_to) begin
                m_last = m_own; m_own = -1;
            end else if ((m_g >= 0 && !lock[m_g]) || (!req[m_own] && !lock[m_own])) begin
                m_own = -1;
            end else begin
                m_lcnt++;
            end
        end
    end

    // ---------------- read-data monitor ----------------
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            while (sbq.size() > 0 && sbq[0].c < cyc) void'(sbq.pop_front());
            chk("rvalid_in_reset", 64'(rvalid), 64'd0);
        end else if (sbq.size() > 0 && sbq[0].c == cyc - 1) begin
            chk("rvalid", 64'(rvalid), 64'((sbq[0].id == 1) ? 2'b10 : 2'b01));
            chk("rdata", 64'(rdata), 64'(sbq[0].d));
            void'(sbq.pop_front());
        end else begin
            chk("rvalid_idle", 64'(rvalid), 64'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_req(input int k, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic l);
        req[k] = 1'b1; we[k] = w; lock[k] = l;
        if (k == 0) begin addr0 = a; wdata0 = d; end
        else        begin addr1 = a; wdata1 = d; end
    endtask

    // Holds the current request until granted; returns in the following cycle
    task automatic wait_gnt(input int k);
        bit got = 1'b0;
        int n   = 0;
        while (!got && n < 64) begin
            @(negedge clk); got = gnt[k]; n++;
            @(posedge clk); #1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL wait_gnt%0d: no grant within 64 cycles", k);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = 2'b00; lock = 2'b00; we = 2'b00;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    int         pulses;
    logic       prev_to;
    logic [1:0] gs;

    initial begin
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        do_reset();

        // preload the random-traffic region so every read has a known value
        for (int i = 0; i < 32; i++) begin
            set_req(0, 1'b1, AW'(i), DW'($urandom), 1'b0);
            wait_gnt(0);
        end
        req = 2'b00;

        // write then read back through requester 0
        set_req(0, 1'b1, AW'(105), 32'h1234, 1'b0); wait_gnt(0);
        set_req(0, 1'b0, AW'(105), '0, 1'b0);       wait_gnt(0);
        req = 2'b00; tick(); tick();

        // contention from reset alternates starting with requester 0
        do_reset();
        set_req(0, 1'b0, AW'(1), '0, 1'b0);
        set_req(1, 1'b0, AW'(2), '0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); chk("alternate", 64'(gnt), 64'((i % 2) ? 2'b10 : 2'b01));
            tick();
        end
        req = 2'b00; tick();

        // locked read-modify-write of counter @200 while requester 1 waits
        set_req(0, 1'b1, AW'(200), 32'd7, 1'b0); wait_gnt(0);
        set_req(0, 1'b0, AW'(200), '0, 1'b1);    wait_gnt(0);
        req[0] = 1'b0;
        set_req(1, 1'b0, AW'(3), '0, 1'b0);
        @(negedge clk); chk("rmw_hold_off", 64'(gnt), 64'd0);
        tick();
        set_req(0, 1'b1, AW'(200), 32'd8, 1'b0);
        @(negedge clk); chk("rmw_write", 64'(gnt), 64'd1);
        tick();
        req[0] = 1'b0;
        @(negedge clk); chk("rmw_then_req1", 64'(gnt), 64'd2);
        tick();
        req = 2'b00;
        set_req(0, 1'b0, AW'(200), '0, 1'b0); wait_gnt(0);
        req = 2'b00; tick();

        // requester 1 camps on the lock; forced release after MAXL cycles
        set_req(1, 1'b0, AW'(4), '0, 1'b1); wait_gnt(1);
        set_req(0, 1'b0, AW'(5), '0, 1'b0);
        pulses = 0; prev_to = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (prev_to) chk("gnt0_after_timeout", 64'(gnt), 64'd1);
            prev_to = lock_to;
            if (lock_to) pulses++;
            tick();
        end
        chk("timeout_pulses", 64'(pulses), 64'd1);
        req = 2'b00; lock = 2'b00; tick(); tick();

        // reset in the cycle after a granted read drops its rvalid
        set_req(0, 1'b0, AW'(6), '0, 1'b0); wait_gnt(0);
        rst_n = 1'b0; req[0] = 1'b0;
        set_req(1, 1'b0, AW'(7), '0, 1'b0);
        @(negedge clk);
        chk("reset_rvalid", 64'(rvalid), 64'd0);
        chk("reset_gnt", 64'(gnt), 64'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk); chk("post_reset_gnt1", 64'(gnt), 64'd2);
        tick();
        req = 2'b00; tick();

        // lock abandoned without further access releases at once
        set_req(0, 1'b0, AW'(8), '0, 1'b1); wait_gnt(0);
        req[0] = 1'b0; lock[0] = 1'b0;
        set_req(1, 1'b0, AW'(9), '0, 1'b0);
        @(negedge clk); chk("abandon_gnt", 64'(gnt), 64'd0);
        tick();
        @(negedge clk); chk("abandon_other", 64'(gnt), 64'd2);
        tick();
        req = 2'b00; tick();

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk); gs = gnt;
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                if (!req[k] || gs[k]) begin
                    if ($urandom_range(0, 99) < 60)
                        set_req(k, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)),
                                DW'($urandom), 1'($urandom_range(0, 99) < 30));
                    else begin
                        req[k]  = 1'b0;
                        lock[k] = 1'($urandom_range(0, 99) < 15);
                    end
                end
            end
        end
        req = 2'b00; lock = 2'b00;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
